// File: rtl/updown_load_counter.sv
// Up/down binary counter with synchronous parallel load, all-ones/zero status
// flags and a registered pulse marking each modular wrap.
module updown_load_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load,
  input  logic             down,
  output logic [WIDTH-1:0] count,
  output logic             rollover,
  output logic             zero,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;

  // Load wins over counting and never reports a wrap, even all-ones -> zero.
  always_comb begin
    count_nxt = count + ONE;
    wrap_nxt  = 1'b0;
    if (load_en) begin
      count_nxt = load;
      wrap_nxt  = 1'b0;
    end else if (down) begin
      count_nxt = count - ONE;
      wrap_nxt  = (count == '0);
    end else begin
      count_nxt = count + ONE;
      wrap_nxt  = (count == ALL_ONES);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= count_nxt;
      wrap  <= wrap_nxt;
    end
  end

  assign rollover = &count;
  assign zero     = ~|count;

endmodule

// File: tb/tb_updown_load_counter.sv
// Bench for updown_load_counter: table-driven vectors through an expected
// queue, a modelled random run, and hand sequences for reset and WIDTH=1.
module tb_updown_load_counter;

  logic       clk;
  logic       rstn;
  logic       load_en;
  logic [3:0] load;
  logic       down;
  logic [3:0] count;
  logic       rollover, zero, wrap;
  logic [0:0] count1;
  logic       rollover1, zero1, wrap1;
  logic [0:0] load1;

  int n_checks = 0;
  int n_pass   = 0;
  logic [6:0] exp_q[$];

  assign load1 = load[0:0];

  updown_load_counter #(.WIDTH(4)) u_dut (
    .clk(clk), .rstn(rstn), .load_en(load_en), .load(load), .down(down),
    .count(count), .rollover(rollover), .zero(zero), .wrap(wrap)
  );

  updown_load_counter #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .load_en(load_en), .load(load1), .down(down),
    .count(count1), .rollover(rollover1), .zero(zero1), .wrap(wrap1)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       le;
    logic [3:0] ld;
    logic       dn;
    logic [3:0] c;
    logic       r;
    logic       z;
    logic       w;
    string      name;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [6:0] pk(input logic [3:0] c, input logic r,
                                    input logic z, input logic w);
    return {c, r, z, w};
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got count=%h r/z/w=%b required count=%h r/z/w=%b",
               name, act[6:3], act[2:0], exp[6:3], exp[2:0]);
    else
      n_pass++;
  endtask

  // Drive at negedge, expect after the following posedge (4-bit instance).
  task automatic step(input logic rst, input logic le, input logic [3:0] ld,
                      input logic dn, input logic [6:0] exp, input string name);
    @(negedge clk);
    rstn = rst; load_en = le; load = ld; down = dn;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    check(name, {count, rollover, zero, wrap}, exp_q.pop_front());
  endtask

  // Same, observing the WIDTH=1 instance.
  task automatic step1(input logic rst, input logic le, input logic ld,
                       input logic dn, input logic [6:0] exp, input string name);
    @(negedge clk);
    rstn = rst; load_en = le; load = {3'b000, ld}; down = dn;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    check(name, {3'b000, count1, rollover1, zero1, wrap1}, exp_q.pop_front());
  endtask

  initial begin
    logic [3:0] m, nm, rl;
    logic       rle, rdn, w;

    rstn = 1'b0; load_en = 1'b0; load = 4'h0; down = 1'b0;

    // reset held while inputs toggle
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), pk(4'h0, 1'b0, 1'b1, 1'b0), "reset_hold");
    step(1'b1, 1'b0, 4'h0, 1'b0, pk(4'h1, 1'b0, 1'b0, 1'b0), "release_first");

    vecs.push_back('{1'b0, 4'h0, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0, "count_up_2"});
    vecs.push_back('{1'b0, 4'h0, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, "count_up_3"});
    vecs.push_back('{1'b1, 4'h8, 1'b1, 4'h8, 1'b0, 1'b0, 1'b0, "load_over_down"});
    vecs.push_back('{1'b1, 4'hC, 1'b0, 4'hC, 1'b0, 1'b0, 1'b0, "load_c"});
    vecs.push_back('{1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, "load_zero"});
    vecs.push_back('{1'b1, 4'hE, 1'b0, 4'hE, 1'b0, 1'b0, 1'b0, "load_e"});
    vecs.push_back('{1'b0, 4'h0, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, "up_to_f"});
    vecs.push_back('{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, "up_wrap"});
    vecs.push_back('{1'b0, 4'h0, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0, "up_after_wrap"});
    vecs.push_back('{1'b1, 4'h1, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0, "load_1"});
    vecs.push_back('{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, "down_to_0"});
    vecs.push_back('{1'b0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b1, "down_wrap"});
    vecs.push_back('{1'b0, 4'h0, 1'b1, 4'hE, 1'b0, 1'b0, 1'b0, "down_after_wrap"});
    vecs.push_back('{1'b1, 4'hF, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, "load_ones"});
    vecs.push_back('{1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, "load_ones_to_zero"});
    vecs.push_back('{1'b1, 4'hE, 1'b1, 4'hE, 1'b0, 1'b0, 1'b0, "load_e_again"});
    vecs.push_back('{1'b0, 4'h0, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, "dir_up_f"});
    vecs.push_back('{1'b0, 4'h0, 1'b1, 4'hE, 1'b0, 1'b0, 1'b0, "dir_down_e"});

    foreach (vecs[i])
      step(1'b1, vecs[i].le, vecs[i].ld, vecs[i].dn,
           pk(vecs[i].c, vecs[i].r, vecs[i].z, vecs[i].w), vecs[i].name);

    // random run against a behavioural model, starting from 0xE
    m = 4'hE;
    for (int i = 0; i < 40; i++) begin
      rle = ($urandom_range(0, 3) == 0);
      rl  = 4'($urandom_range(0, 15));
      rdn = 1'($urandom_range(0, 1));
      if (rle) begin
        nm = rl; w = 1'b0;
      end else if (rdn) begin
        nm = m - 4'd1; w = (m == 4'h0);
      end else begin
        nm = m + 4'd1; w = (m == 4'hF);
      end
      step(1'b1, rle, rl, rdn, pk(nm, nm == 4'hF, nm == 4'h0, w), "random");
      m = nm;
    end

    // asynchronous reset between edges while counting up from 5
    step(1'b1, 1'b1, 4'h4, 1'b0, pk(4'h4, 1'b0, 1'b0, 1'b0), "load_4");
    step(1'b1, 1'b0, 4'h0, 1'b0, pk(4'h5, 1'b0, 1'b0, 1'b0), "up_to_5");
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("async_reset_no_edge", {count, rollover, zero, wrap}, pk(4'h0, 1'b0, 1'b1, 1'b0));
    step(1'b0, 1'b1, 4'h9, 1'b0, pk(4'h0, 1'b0, 1'b1, 1'b0), "reset_aborts_load");
    step(1'b1, 1'b0, 4'h0, 1'b0, pk(4'h1, 1'b0, 1'b0, 1'b0), "release_after_async");
    step(1'b1, 1'b0, 4'h0, 1'b0, pk(4'h2, 1'b0, 1'b0, 1'b0), "up_after_release");

    // WIDTH=1 instance: every non-load edge wraps
    step1(1'b0, 1'b0, 1'b0, 1'b0, {3'b000, 1'b0, 1'b0, 1'b1, 1'b0}, "w1_reset");
    step1(1'b1, 1'b1, 1'b1, 1'b0, {3'b000, 1'b1, 1'b1, 1'b0, 1'b0}, "w1_load_1");
    step1(1'b1, 1'b0, 1'b0, 1'b0, {3'b000, 1'b0, 1'b0, 1'b1, 1'b1}, "w1_up_wrap");
    step1(1'b1, 1'b0, 1'b0, 1'b1, {3'b000, 1'b1, 1'b1, 1'b0, 1'b1}, "w1_down_wrap");
    step1(1'b1, 1'b1, 1'b0, 1'b1, {3'b000, 1'b0, 1'b0, 1'b1, 1'b0}, "w1_load_0");
    step1(1'b1, 1'b0, 1'b0, 1'b1, {3'b000, 1'b1, 1'b1, 1'b0, 1'b1}, "w1_down_wrap2");
    step1(1'b1, 1'b0, 1'b0, 1'b0, {3'b000, 1'b0, 1'b0, 1'b1, 1'b1}, "w1_up_wrap2");

    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL queue_drain: got %0d entries left required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
